// File: rtl/lcd_ctrl_pkg.sv
// Shared encodings for the LCD sequencer: FSM states, strobe phases and
// the select codes presented to LCD_dp.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHAR
    } lcd_fsm_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EHIGH,
        PH_WAIT
    } strobe_ph_e;

    localparam logic [1:0] INIT_FUNCSET = 2'd3;
    localparam logic [1:0] INIT_ENTRY   = 2'd2;
    localparam logic [1:0] INIT_DISPON  = 2'd1;
    localparam logic [1:0] INIT_CLEAR   = 2'd0;

    localparam logic [1:0] FIELD_NUMBER = 2'd0;
    localparam logic [1:0] FIELD_OPTEXT = 2'd1;
    localparam logic [1:0] FIELD_BLANK  = 2'd2;

    localparam logic [1:0] INDEX_LAST   = 2'd3;

endpackage

// File: rtl/lcd_ctrl_strobe.sv
// One HD44780 transfer: SETUP (E low), EHIGH (E high), then a post-transfer
// wait whose length is latched when the transfer is launched.
module lcd_strobe
    import lcd_ctrl_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CW      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic long_wait,
    output logic E,
    output logic done
);

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EHIGH_LAST = CW'(T_EHIGH - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(T_CLEAR - 1);

    strobe_ph_e    ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          long_q, long_d;
    logic          e_q;
    logic [CW-1:0] wait_last;

    assign wait_last = long_q ? CLEAR_LAST : CMD_LAST;

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q + 1'b1;
        long_d = long_q;
        done   = 1'b0;
        case (ph_q)
            PH_IDLE: begin
                cnt_d = '0;
                if (go) begin
                    ph_d   = PH_SETUP;
                    long_d = long_wait;
                end
            end
            PH_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    ph_d  = PH_EHIGH;
                    cnt_d = '0;
                end
            end
            PH_EHIGH: begin
                if (cnt_q == EHIGH_LAST) begin
                    ph_d  = PH_WAIT;
                    cnt_d = '0;
                end
            end
            PH_WAIT: begin
                if (cnt_q == wait_last) begin
                    // A launch on the final wait cycle chains straight into SETUP.
                    done   = 1'b1;
                    cnt_d  = '0;
                    long_d = long_wait;
                    ph_d   = go ? PH_SETUP : PH_IDLE;
                end
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q   <= PH_IDLE;
            cnt_q  <= '0;
            long_q <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            long_q <= long_d;
            e_q    <= (ph_d == PH_EHIGH);
        end
    end

    assign E = e_q;

endmodule

// File: rtl/lcd_ctrl.sv
// LCD sequencer: power-up delay, four init commands, then on request an
// address command followed by 12 characters (3 fields x 4 digits).
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EHIGH = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 82000,
    parameter int CW      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    output logic [1:0] init_sel,
    output logic       data_sel,
    output logic       DB_sel,
    output logic [1:0] state,
    output logic [1:0] index,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       ready
);

    localparam logic [CW-1:0] PWRUP_LAST = CW'(T_PWRUP - 1);

    lcd_fsm_e      fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_sel_q, init_sel_d;
    logic          data_sel_q, data_sel_d;
    logic          db_sel_q, db_sel_d;
    logic [1:0]    field_q, field_d;
    logic [1:0]    index_q, index_d;
    logic          rs_q, rs_d;
    logic          ready_q, ready_d;
    logic          pending_q, pending_d;
    logic          go, long_wait, done;

    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        init_sel_d = init_sel_q;
        data_sel_d = data_sel_q;
        db_sel_d   = db_sel_q;
        field_d    = field_q;
        index_d    = index_q;
        rs_d       = rs_q;
        ready_d    = ready_q;
        pending_d  = pending_q | (refresh & ~ready_q);
        go         = 1'b0;
        case (fsm_q)
            ST_PWRUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PWRUP_LAST) begin
                    fsm_d      = ST_INIT;
                    cnt_d      = '0;
                    init_sel_d = INIT_FUNCSET;
                    data_sel_d = 1'b0;
                    db_sel_d   = 1'b1;
                    rs_d       = 1'b0;
                    go         = 1'b1;
                end
            end
            ST_INIT: begin
                if (done) begin
                    if (init_sel_q == INIT_CLEAR) begin
                        fsm_d   = ST_IDLE;
                        ready_d = 1'b1;
                    end else begin
                        init_sel_d = init_sel_q - 2'd1;
                        go         = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (refresh || pending_q) begin
                    fsm_d     = ST_ADDR;
                    ready_d   = 1'b0;
                    pending_d = 1'b0;
                    db_sel_d  = 1'b0;
                    rs_d      = 1'b0;
                    go        = 1'b1;
                end
            end
            ST_ADDR: begin
                if (done) begin
                    fsm_d      = ST_CHAR;
                    db_sel_d   = 1'b1;
                    data_sel_d = 1'b1;
                    rs_d       = 1'b1;
                    field_d    = FIELD_NUMBER;
                    index_d    = 2'd0;
                    go         = 1'b1;
                end
            end
            ST_CHAR: begin
                if (done) begin
                    if (field_q == FIELD_BLANK && index_q == INDEX_LAST) begin
                        fsm_d   = ST_IDLE;
                        field_d = FIELD_NUMBER;
                        index_d = 2'd0;
                        ready_d = 1'b1;
                    end else begin
                        if (index_q == INDEX_LAST) begin
                            index_d = 2'd0;
                            field_d = field_q + 2'd1;
                        end else begin
                            index_d = index_q + 2'd1;
                        end
                        go = 1'b1;
                    end
                end
            end
            default: fsm_d = ST_PWRUP;
        endcase
    end

    // Only the clear command needs the long post-transfer wait.
    assign long_wait = (fsm_d == ST_INIT) && (init_sel_d == INIT_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_PWRUP;
            cnt_q      <= '0;
            init_sel_q <= INIT_FUNCSET;
            data_sel_q <= 1'b0;
            db_sel_q   <= 1'b1;
            field_q    <= FIELD_NUMBER;
            index_q    <= 2'd0;
            rs_q       <= 1'b0;
            ready_q    <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            init_sel_q <= init_sel_d;
            data_sel_q <= data_sel_d;
            db_sel_q   <= db_sel_d;
            field_q    <= field_d;
            index_q    <= index_d;
            rs_q       <= rs_d;
            ready_q    <= ready_d;
            pending_q  <= pending_d;
        end
    end

    lcd_strobe #(
        .T_SETUP (T_SETUP),
        .T_EHIGH (T_EHIGH),
        .T_CMD   (T_CMD),
        .T_CLEAR (T_CLEAR),
        .CW      (CW)
    ) u_strobe (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .long_wait (long_wait),
        .E         (LCD_E),
        .done      (done)
    );

    assign init_sel = init_sel_q;
    assign data_sel = data_sel_q;
    assign DB_sel   = db_sel_q;
    assign state    = field_q;
    assign index    = index_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign ready    = ready_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; a monitor logs every
// E pulse and ready rise, and the stimulus block checks the log.
module tb_lcd_ctrl;

    localparam int TP  = 20;
    localparam int TS  = 2;
    localparam int TE  = 3;
    localparam int TC  = 5;
    localparam int TCL = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh = 1'b0;
    logic [1:0] init_sel;
    logic       data_sel;
    logic       DB_sel;
    logic [1:0] state;
    logic [1:0] index;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       ready;

    lcd_ctrl #(
        .T_PWRUP (TP),
        .T_SETUP (TS),
        .T_EHIGH (TE),
        .T_CMD   (TC),
        .T_CLEAR (TCL),
        .CW      (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .refresh  (refresh),
        .init_sel (init_sel),
        .data_sel (data_sel),
        .DB_sel   (DB_sel),
        .state    (state),
        .index    (index),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] isel;
        logic       ds;
        logic       db;
        logic       rs;
        logic [1:0] st;
        logic [1:0] idx;
        int         t_rise;
        int         width;
    } pulse_t;

    pulse_t log_q[$];
    int     rdy_tq[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     rw_bad  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse logger and select-stability checker.
    initial begin
        logic       e_prev;
        logic       r_prev;
        logic [8:0] sel, h1, h2;
        e_prev = 1'b0;
        r_prev = 1'b0;
        h1 = '0;
        h2 = '0;
        forever begin
            @(negedge clk);
            sel = {init_sel, data_sel, DB_sel, LCD_RS, state, index};
            if (!rst) begin
                if (LCD_E && !e_prev) begin
                    chk("sel_setup", 32'({sel, sel}), 32'({h1, h2}));
                    log_q.push_back('{init_sel, data_sel, DB_sel, LCD_RS, state, index, cyc, 0});
                end else if (LCD_E && e_prev) begin
                    chk("sel_ehigh", 32'(sel), 32'(h1));
                end
                if (!LCD_E && e_prev && log_q.size() > 0)
                    log_q[log_q.size()-1].width = cyc - log_q[log_q.size()-1].t_rise;
                if (ready && !r_prev) rdy_tq.push_back(cyc);
                if (LCD_RW !== 1'b0) rw_bad++;
            end
            e_prev = LCD_E;
            r_prev = ready;
            h2 = h1;
            h1 = sel;
        end
    end

    task automatic release_reset(output int c0);
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        rdy_tq.delete();
        c0 = cyc;
    endtask

    task automatic pulse_refresh(output int t);
        @(negedge clk);
        refresh = 1'b1;
        t = cyc;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic wait_rdy(input int target, input int bound, input string tag);
        int k = 0;
        while (rdy_tq.size() < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rdy_tq.size() >= target), 32'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_E"}, 32'(LCD_E), 0);
        chk({tag, "_RS"}, 32'(LCD_RS), 0);
        chk({tag, "_RW"}, 32'(LCD_RW), 0);
        chk({tag, "_init_sel"}, 32'(init_sel), 3);
        chk({tag, "_data_sel"}, 32'(data_sel), 0);
        chk({tag, "_DB_sel"}, 32'(DB_sel), 1);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_index"}, 32'(index), 0);
        chk({tag, "_ready"}, 32'(ready), 0);
    endtask

    // Checks a 13-pulse frame starting at log entry b.
    task automatic check_frame(input int b, input string tag);
        chk({tag, "_addr_rs_db"}, 32'({log_q[b].rs, log_q[b].db}), 32'(0));
        chk({tag, "_addr_w"}, 32'(log_q[b].width), 32'(TE));
        for (int k = 1; k <= 12; k++) begin
            chk({tag, "_char"}, 32'({log_q[b+k].rs, log_q[b+k].db, log_q[b+k].ds,
                                     log_q[b+k].st, log_q[b+k].idx}),
                32'({3'b111, 2'((k-1)/4), 2'((k-1)%4)}));
            chk({tag, "_char_w"}, 32'(log_q[b+k].width), 32'(TE));
            chk({tag, "_char_gap"}, 32'(log_q[b+k].t_rise - log_q[b+k-1].t_rise), 32'(TE + TC + TS));
        end
    endtask

    initial begin
        int c0, tr, k;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");

        // Power-up and init sequence
        release_reset(c0);
        wait_rdy(1, 500, "init_ready_timeout");
        chk("init_npulses", 32'(log_q.size()), 32'(4));
        if (log_q.size() >= 4) begin
            chk("init_first_rise", 32'(log_q[0].t_rise - c0), 32'(TP + TS));
            for (int i = 0; i < 4; i++) begin
                chk("init_sel_ds_db_rs", 32'({log_q[i].isel, log_q[i].ds, log_q[i].db, log_q[i].rs}),
                    32'({2'(3 - i), 3'b010}));
                chk("init_width", 32'(log_q[i].width), 32'(TE));
                if (i > 0)
                    chk("init_gap", 32'(log_q[i].t_rise - log_q[i-1].t_rise), 32'(TE + TC + TS));
            end
            chk("clear_wait", 32'(rdy_tq[0] - log_q[3].t_rise), 32'(TE + TCL));
        end

        // Single refresh in IDLE
        log_q.delete();
        pulse_refresh(tr);
        wait_rdy(2, 500, "frame_ready_timeout");
        chk("frame_npulses", 32'(log_q.size()), 32'(13));
        if (log_q.size() >= 13) begin
            chk("frame_latency", 32'(log_q[0].t_rise - tr), 32'(1 + TS));
            check_frame(0, "frame");
            chk("frame_end_wait", 32'(rdy_tq[1] - log_q[12].t_rise), 32'(TE + TC));
        end
        chk("frame_end_state", 32'({state, index, ready}), 32'(1));
        chk("rw_low", 32'(rw_bad), 32'(0));

        // Three refreshes during power-up/init collapse to one frame
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_reset(c0);
        repeat (4) @(negedge clk);
        pulse_refresh(tr);
        repeat (5) @(negedge clk);
        pulse_refresh(tr);
        repeat (20) @(negedge clk);
        pulse_refresh(tr);
        wait_rdy(2, 1000, "pend_ready_timeout");
        chk("pend_npulses", 32'(log_q.size()), 32'(17));
        if (log_q.size() >= 17) begin
            chk("pend_immediate", 32'(log_q[4].t_rise - rdy_tq[0]), 32'(1 + TS));
            check_frame(4, "pend");
        end
        repeat (60) @(negedge clk);
        chk("pend_no_extra", 32'(log_q.size()), 32'(17));

        // Refresh during a frame queues exactly one further frame
        log_q.delete();
        rdy_tq.delete();
        pulse_refresh(tr);
        repeat (40) @(negedge clk);
        pulse_refresh(tr);
        repeat (20) @(negedge clk);
        pulse_refresh(tr);
        wait_rdy(2, 1000, "back2back_ready_timeout");
        chk("back2back_npulses", 32'(log_q.size()), 32'(26));
        if (log_q.size() >= 26) begin
            chk("back2back_immediate", 32'(log_q[13].t_rise - rdy_tq[0]), 32'(1 + TS));
            check_frame(13, "back2back");
        end
        repeat (60) @(negedge clk);
        chk("back2back_no_extra", 32'(log_q.size()), 32'(26));

        // Reset during EHIGH of the fifth character
        log_q.delete();
        pulse_refresh(tr);
        k = 0;
        while (log_q.size() < 6 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("char5_reached", 32'(log_q.size() >= 6), 32'(1));
        chk("char5_E_high", 32'(LCD_E), 32'(1));
        if (log_q.size() >= 6)
            chk("char5_field_idx", 32'({log_q[5].st, log_q[5].idx}), 32'({2'd1, 2'd0}));
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        release_reset(c0);
        k = 0;
        while (log_q.size() < 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("restart_pulse_seen", 32'(log_q.size() >= 1), 32'(1));
        if (log_q.size() >= 1) begin
            chk("restart_first_rise", 32'(log_q[0].t_rise - c0), 32'(TP + TS));
            chk("restart_init_sel", 32'(log_q[0].isel), 32'(3));
        end
        chk("rw_low_end", 32'(rw_bad), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
